// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding scoreboard.
package hazard_pkg;

    // Slot rd is stored at a fixed width wide enough for any register file we use.
    localparam int REG_AW_MAX = 8;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rd;
        logic                  wr_en;
        logic                  is_load;
    } slot_t;

    localparam int SEL_RF        = 0;
    localparam int INV_IF        = 0;
    localparam int INV_ID        = 1;
    localparam int INV_SLOT_BASE = 2;

    function automatic int sel_w(input int n_stages);
        return $clog2(n_stages + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request / hazard-control response bundle of the scoreboard.
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int N_SRC    = 2,
    parameter int N_STAGES = 3,
    parameter int CNT_W    = 32
);
    localparam int SW = sel_w(N_STAGES);

    logic                    id_valid;
    logic [N_SRC*REG_AW-1:0] id_rs;
    logic [N_SRC-1:0]        id_rs_used;
    logic [REG_AW-1:0]       id_rd;
    logic                    id_wr_en;
    logic                    id_is_load;
    logic                    mem_ready;
    logic                    br_taken;
    logic                    excep;
    logic [N_SRC*SW-1:0]     fwd_sel;
    logic                    stall_if;
    logic                    stall_id;
    logic [N_STAGES+1:0]     inval;
    logic [CNT_W-1:0]        stall_cnt;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_wr_en, id_is_load,
        output mem_ready, br_taken, excep,
        input  fwd_sel, stall_if, stall_id, inval, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_wr_en, id_is_load,
        input  mem_ready, br_taken, excep,
        output fwd_sel, stall_if, stall_id, inval, stall_cnt
    );

endinterface

// File: rtl/hazard_fwd_match.sv
// Youngest-producer priority encoder for one source operand.
module hazard_fwd_match
    import hazard_pkg::*;
#(
    parameter  int REG_AW   = 5,
    parameter  int N_STAGES = 3,
    parameter  int LOAD_RDY = 2,
    localparam int SW       = sel_w(N_STAGES)
) (
    input  logic                   en,
    input  logic [REG_AW-1:0]      rs,
    input  slot_t [N_STAGES:1]     slots,
    output logic [SW-1:0]          sel,
    output logic                   not_ready
);

    always_comb begin
        sel       = SW'(SEL_RF);
        not_ready = 1'b0;
        // Scan oldest to youngest so the youngest match is the last one written.
        for (int k = N_STAGES; k >= 1; k--) begin
            if (en && (rs != '0) && slots[k].valid && slots[k].wr_en &&
                (slots[k].rd == REG_AW_MAX'(rs))) begin
                sel       = SW'(k);
                not_ready = slots[k].is_load && (k < LOAD_RDY);
            end
        end
        if (not_ready) begin
            sel = SW'(SEL_RF);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Parametrised hazard/forwarding unit: tracks in-flight destinations behind ID,
// selects forwarding sources, stalls on unready loads and applies flushes.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int N_SRC    = 2,
    parameter int N_STAGES = 3,
    parameter int LOAD_RDY = 2,
    parameter int CNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave bus
);

    localparam int SW         = sel_w(N_STAGES);
    localparam int N_EXC_KILL = (N_STAGES < 3) ? N_STAGES : 3;

    slot_t [N_STAGES:1]  slot_reg, slot_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [N_SRC-1:0]    not_ready;
    logic [N_SRC*SW-1:0] sel_raw;
    logic [N_STAGES+1:0] inval_raw;
    logic                flush, hz, stall, load_id;

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_src
            hazard_fwd_match #(
                .REG_AW   (REG_AW),
                .N_STAGES (N_STAGES),
                .LOAD_RDY (LOAD_RDY)
            ) u_match (
                .en        (bus.id_valid & bus.id_rs_used[gi]),
                .rs        (bus.id_rs[gi*REG_AW +: REG_AW]),
                .slots     (slot_reg),
                .sel       (sel_raw[gi*SW +: SW]),
                .not_ready (not_ready[gi])
            );
        end
    endgenerate

    assign flush   = bus.br_taken | bus.excep;
    assign hz      = |not_ready;
    assign stall   = (hz | ~bus.mem_ready) & ~flush;
    assign load_id = bus.id_valid & ~stall & ~flush;

    always_comb begin
        slot_next = slot_reg;
        // A flush forces the shift even under memory back-pressure.
        if (bus.mem_ready || flush) begin
            for (int k = N_STAGES; k >= 2; k--) begin
                slot_next[k] = slot_reg[k-1];
            end
            slot_next[1] = '0;
            if (load_id) begin
                slot_next[1].valid   = 1'b1;
                slot_next[1].rd      = REG_AW_MAX'(bus.id_rd);
                slot_next[1].wr_en   = bus.id_wr_en;
                slot_next[1].is_load = bus.id_is_load;
            end
            if (bus.excep) begin
                for (int k = 1; k <= N_EXC_KILL; k++) begin
                    slot_next[k].valid = 1'b0;
                end
            end
        end
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (stall && (cnt_reg != '1)) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_comb begin
        inval_raw                  = '0;
        inval_raw[INV_IF]          = bus.br_taken;
        inval_raw[INV_ID]          = flush;
        inval_raw[INV_SLOT_BASE]   = flush;
        inval_raw[INV_SLOT_BASE+1] = flush;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            slot_reg <= slot_next;
            cnt_reg  <= cnt_next;
        end
    end

    // Outputs are forced quiet while reset is held, even before the first edge.
    assign bus.fwd_sel   = reset ? '0 : sel_raw;
    assign bus.stall_if  = stall & ~reset;
    assign bus.stall_id  = stall & ~reset;
    assign bus.inval     = reset ? '0 : inval_raw;
    assign bus.stall_cnt = reset ? '0 : cnt_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Table-driven check of hazard_scoreboard plus a short saturation / LOAD_RDY=1 sequence.
module tb_hazard_scoreboard;

    logic clk;
    logic reset;
    logic reset2;

    hazard_scoreboard_if #(.REG_AW(5), .N_SRC(2), .N_STAGES(3), .CNT_W(32)) bus ();
    hazard_scoreboard_if #(.REG_AW(5), .N_SRC(2), .N_STAGES(3), .CNT_W(2))  bus2 ();

    hazard_scoreboard #(
        .REG_AW(5), .N_SRC(2), .N_STAGES(3), .LOAD_RDY(2), .CNT_W(32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    hazard_scoreboard #(
        .REG_AW(5), .N_SRC(2), .N_STAGES(3), .LOAD_RDY(1), .CNT_W(2)
    ) dut2 (
        .clk   (clk),
        .reset (reset2),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic [1:0]  used;
        logic [4:0]  rd;
        logic        wr;
        logic        ld;
        logic        mr;
        logic        br;
        logic        ex;
        logic [1:0]  s0;
        logic [1:0]  s1;
        logic        stall;
        logic [4:0]  inv;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cur   = 0;

    function automatic vec_t mk(input int rst, v, rs0, rs1, used, rd, wr, ld, mr, br, ex,
                                input int s0, s1, stall, inv, cnt);
        vec_t r;
        r.rst = 1'(rst); r.v = 1'(v); r.rs0 = 5'(rs0); r.rs1 = 5'(rs1);
        r.used = 2'(used); r.rd = 5'(rd); r.wr = 1'(wr); r.ld = 1'(ld);
        r.mr = 1'(mr); r.br = 1'(br); r.ex = 1'(ex);
        r.s0 = 2'(s0); r.s1 = 2'(s1); r.stall = 1'(stall); r.inv = 5'(inv);
        r.cnt = 32'(cnt);
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0h want=%0h", nm, cur, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t t);
        vec_t e;
        reset           = t.rst;
        bus.id_valid    = t.v;
        bus.id_rs       = {t.rs1, t.rs0};
        bus.id_rs_used  = t.used;
        bus.id_rd       = t.rd;
        bus.id_wr_en    = t.wr;
        bus.id_is_load  = t.ld;
        bus.mem_ready   = t.mr;
        bus.br_taken    = t.br;
        bus.excep       = t.ex;
        sb.push_back(t);
        @(negedge clk);
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("fwd_sel0", 32'(bus.fwd_sel[1:0]), 32'(e.s0));
            check("fwd_sel1", 32'(bus.fwd_sel[3:2]), 32'(e.s1));
            check("stall_id", 32'(bus.stall_id), 32'(e.stall));
            check("stall_if", 32'(bus.stall_if), 32'(e.stall));
            check("inval", 32'(bus.inval), 32'(e.inv));
            check("stall_cnt", bus.stall_cnt, e.cnt);
            $display("step %0d sel=%0d/%0d stall=%0b inval=%05b cnt=%0d",
                     cur, bus.fwd_sel[1:0], bus.fwd_sel[3:2], bus.stall_id,
                     bus.inval, bus.stall_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input int v, rs0, used, rd, wr, ld, mr,
                         input int e_sel0, e_stall, e_cnt);
        bus2.id_valid   = 1'(v);
        bus2.id_rs      = {5'd0, 5'(rs0)};
        bus2.id_rs_used = 2'(used);
        bus2.id_rd      = 5'(rd);
        bus2.id_wr_en   = 1'(wr);
        bus2.id_is_load = 1'(ld);
        bus2.mem_ready  = 1'(mr);
        @(negedge clk);
        check("u2_fwd_sel0", 32'(bus2.fwd_sel[1:0]), 32'(e_sel0));
        check("u2_stall", 32'(bus2.stall_id), 32'(e_stall));
        check("u2_stall_cnt", 32'(bus2.stall_cnt), 32'(e_cnt));
        $display("u2 step %0d sel0=%0d stall=%0b cnt=%0d",
                 cur, bus2.fwd_sel[1:0], bus2.stall_id, bus2.stall_cnt);
        cur++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        reset2 = 1'b1;
        bus.id_valid = 0; bus.id_rs = '0; bus.id_rs_used = '0; bus.id_rd = '0;
        bus.id_wr_en = 0; bus.id_is_load = 0; bus.mem_ready = 1; bus.br_taken = 0; bus.excep = 0;
        bus2.id_valid = 0; bus2.id_rs = '0; bus2.id_rs_used = '0; bus2.id_rd = '0;
        bus2.id_wr_en = 0; bus2.id_is_load = 0; bus2.mem_ready = 1; bus2.br_taken = 0; bus2.excep = 0;

        //              rst v rs0 rs1 u rd wr ld mr br ex  s0 s1 st inv cnt
        tbl.push_back(mk(1, 1, 5, 5, 3, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 5, 5, 3, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        // back-to-back ALU forwarding
        tbl.push_back(mk(0, 1, 1, 2, 3, 5, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5, 5, 3, 6, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5, 0, 1, 7, 1, 0, 1, 0, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5, 0, 1, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 7, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // load-use: one stall cycle, then forward from slot 2
        tbl.push_back(mk(0, 1, 1, 0, 1, 7, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 7, 0, 3, 8, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 7, 0, 3, 8, 1, 0, 1, 0, 0, 2, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 8, 7, 3, 9, 1, 0, 1, 0, 0, 1, 3, 0, 0, 1));
        // x0 never forwarded; youngest of two writers wins
        tbl.push_back(mk(0, 1, 3, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 3, 9, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 9, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 1));
        // memory freeze for three cycles, then resume
        tbl.push_back(mk(0, 1, 1, 9, 3, 2, 1, 0, 0, 0, 0, 1, 2, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 9, 3, 2, 1, 0, 0, 0, 0, 1, 2, 1, 0, 2));
        tbl.push_back(mk(0, 1, 1, 9, 3, 2, 1, 0, 0, 0, 0, 1, 2, 1, 0, 3));
        tbl.push_back(mk(0, 1, 1, 9, 3, 2, 1, 0, 1, 0, 0, 1, 2, 0, 0, 4));
        tbl.push_back(mk(0, 1, 9, 1, 3, 3, 1, 0, 1, 0, 0, 3, 2, 0, 0, 4));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // branch taken over a load-use hazard
        tbl.push_back(mk(0, 1, 0, 0, 0, 7, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 7, 0, 1, 8, 1, 0, 1, 1, 0, 0, 0, 0, 15, 0));
        tbl.push_back(mk(0, 1, 8, 7, 3, 10, 1, 0, 1, 0, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // exception over the same hazard; then both flushes under freeze
        tbl.push_back(mk(0, 1, 0, 0, 0, 7, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 7, 0, 1, 8, 1, 0, 1, 0, 1, 0, 0, 0, 14, 0));
        tbl.push_back(mk(0, 1, 8, 7, 3, 10, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 10, 0, 1, 11, 1, 0, 0, 1, 1, 1, 0, 0, 15, 0));
        tbl.push_back(mk(0, 1, 10, 0, 1, 12, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // reset asserted during a stall
        tbl.push_back(mk(0, 1, 0, 0, 0, 7, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 7, 0, 1, 8, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 7, 0, 1, 8, 1, 0, 0, 0, 0, 2, 0, 1, 0, 1));
        tbl.push_back(mk(1, 1, 7, 0, 1, 8, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 7, 0, 1, 8, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            cur = i;
            apply_vec(tbl[i]);
        end

        // LOAD_RDY=1 instance: no load-use stall; 2-bit counter saturates at 3
        cur = 100;
        reset2 = 1'b1;
        step2(1, 7, 1, 7, 1, 1, 1, 0, 0, 0);
        reset2 = 1'b0;
        step2(1, 0, 0, 7, 1, 1, 1, 0, 0, 0);
        step2(1, 7, 1, 8, 1, 0, 1, 1, 0, 0);
        step2(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step2(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step2(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        step2(0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        step2(0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        step2(0, 0, 0, 0, 0, 0, 1, 0, 0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
